div_unit: RTL and testbench

Sequential signed fixed-point divider that feeds the division register file. It accepts one operand pair plus a destination index per handshake and computes (dividend << FRAC) / divisor by restoring division, one quotient bit per cycle. It then issues a single-cycle write (wr_en/addr/D) that connects directly to the register file's write side. It sits between the correlation/projection datapath, which produces dividend/divisor pairs, and the division register file.

---
 rtl/div_unit_pkg.sv | 15 +
 rtl/div_sat.sv | 28 ++
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared widths and state encoding for the fixed-point divider slice.
package div_unit_pkg;

  localparam int unsigned REG_DIV_DATA_WIDTH = 16;
  localparam int unsigned REG_DIV_ADDR_WIDTH = 4;
  localparam int unsigned DIV_OP_WIDTH       = 16;
  localparam int unsigned DIV_FRAC           = 8;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_CALC  = 2'd1,
    DIV_WRITE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_sat.sv
// Applies the result sign to an unsigned quotient magnitude and saturates it
// into a QW-bit two's complement value. A zero magnitude yields zero.
module div_sat #(
  parameter int unsigned MW = 24,
  parameter int unsigned QW = 16
) (
  input  logic [MW-1:0] mag,
  input  logic          neg,
  output logic [QW-1:0] d_c
);

  localparam logic [MW-1:0] POS_LIM = MW'((64'd1 << (QW - 1)) - 64'd1);
  localparam logic [MW-1:0] NEG_LIM = MW'(64'd1 << (QW - 1));

  logic [MW-1:0] lim;

  // Clamp magnitude to the representable range for the sign, then negate if needed
  always_comb begin
    lim = mag;
    if (neg) begin
      if (mag > NEG_LIM) lim = NEG_LIM;
    end else begin
      if (mag > POS_LIM) lim = POS_LIM;
    end
    d_c = neg ? QW'(-lim) : QW'(lim);
  end

endmodule

// File: rtl/div_unit.sv
// Sequential signed fixed-point restoring divider: (dividend << FRAC) / divisor,
// one quotient bit per cycle, result written to the division register file.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned W    = DIV_OP_WIDTH,
  parameter int unsigned FRAC = DIV_FRAC,
  parameter int unsigned QW   = REG_DIV_DATA_WIDTH,
  parameter int unsigned AW   = REG_DIV_ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  input  logic [AW-1:0] dst,
  output logic          wr_en,
  output logic [AW-1:0] addr,
  output logic [QW-1:0] D,
  output logic          dz,
  output logic          busy
);

  localparam int unsigned MW = W + FRAC;
  localparam int unsigned CW = $clog2(MW);
  localparam logic [QW-1:0] POS_FULL = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] NEG_FULL = {1'b1, {(QW-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [CW-1:0] cnt;
  logic [W:0]    rem;
  logic [W:0]    dvs_mag;
  logic [MW-1:0] nq;       // shifts the numerator out and the quotient in
  logic          neg_q;
  logic [AW-1:0] dst_q;

  logic          accept;
  logic          divisor_zero;
  logic [W:0]    dvd_ext, dvs_ext, dvd_mag_c, dvs_mag_c;
  logic [W+1:0]  rem_sh;
  logic          take_bit;
  logic [W:0]    rem_step;
  logic [MW-1:0] nq_step;
  logic [QW-1:0] dz_d;
  logic [QW-1:0] sat_d;

  logic          in_ready_n, wr_en_n, busy_n, dz_n;
  logic [AW-1:0] addr_n;
  logic [QW-1:0] d_n;

  // Operand magnitudes and one restoring step
  always_comb begin
    accept       = (state == DIV_IDLE) && in_valid;
    divisor_zero = (divisor == '0);
    dvd_ext      = {dividend[W-1], dividend};
    dvs_ext      = {divisor[W-1], divisor};
    dvd_mag_c    = dvd_ext[W] ? (W+1)'(-dvd_ext) : dvd_ext;
    dvs_mag_c    = dvs_ext[W] ? (W+1)'(-dvs_ext) : dvs_ext;
    rem_sh       = {rem, nq[MW-1]};
    take_bit     = (rem_sh >= {1'b0, dvs_mag});
    rem_step     = take_bit ? (W+1)'(rem_sh - {1'b0, dvs_mag}) : (W+1)'(rem_sh);
    nq_step      = {nq[MW-2:0], take_bit};
    if (dividend == '0)      dz_d = '0;
    else if (dividend[W-1])  dz_d = NEG_FULL;
    else                     dz_d = POS_FULL;
  end

  div_sat #(.MW(MW), .QW(QW)) u_sat (
    .mag (nq_step),
    .neg (neg_q),
    .d_c (sat_d)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE:  if (in_valid) state_nxt = divisor_zero ? DIV_WRITE : DIV_CALC;
      DIV_CALC:  if (cnt == '0) state_nxt = DIV_WRITE;
      DIV_WRITE: state_nxt = DIV_IDLE;
      default:   state_nxt = DIV_IDLE;
    endcase
  end

  // Next values of the registered outputs; result fields load only on entry to WRITE
  always_comb begin
    in_ready_n = (state_nxt == DIV_IDLE);
    wr_en_n    = (state_nxt == DIV_WRITE);
    busy_n     = (state_nxt != DIV_IDLE);
    addr_n     = addr;
    d_n        = D;
    dz_n       = 1'b0;
    if (accept && divisor_zero) begin
      addr_n = dst;
      d_n    = dz_d;
      dz_n   = 1'b1;
    end else if ((state == DIV_CALC) && (cnt == '0)) begin
      addr_n = dst_q;
      d_n    = sat_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      addr     <= '0;
      D        <= '0;
      dz       <= 1'b0;
    end else begin
      in_ready <= in_ready_n;
      wr_en    <= wr_en_n;
      busy     <= busy_n;
      addr     <= addr_n;
      D        <= d_n;
      dz       <= dz_n;
    end
  end

  // Operand capture and iterative datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      rem     <= '0;
      dvs_mag <= '0;
      nq      <= '0;
      neg_q   <= 1'b0;
      dst_q   <= '0;
    end else if (accept) begin
      neg_q   <= dividend[W-1] ^ divisor[W-1];
      dvs_mag <= dvs_mag_c;
      dst_q   <= dst;
      rem     <= '0;
      nq      <= MW'({dvd_mag_c, FRAC'(0)});
      cnt     <= CW'(MW - 1);
    end else if (state == DIV_CALC) begin
      rem <= rem_step;
      nq  <= nq_step;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, random ops against an
// arithmetic reference, back-to-back throughput and mid-operation reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [3:0]  dst;
  logic        wr_en;
  logic [3:0]  addr;
  logic [15:0] D;
  logic        dz;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .dst      (dst),
    .wr_en    (wr_en),
    .addr     (addr),
    .D        (D),
    .dz       (dz),
    .busy     (busy)
  );

  // Register-file sink and write-pulse log
  logic [15:0] rf [16];
  int          cyc = 0;
  int          pulse_cyc [$];
  logic [3:0]  pulse_addr [$];
  logic [15:0] pulse_d [$];

  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      rf[addr] = D;
      pulse_cyc.push_back(cyc);
      pulse_addr.push_back(addr);
      pulse_d.push_back(D);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: Q8 quotient with truncation toward zero, clamped to 16-bit signed
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      if (sa == 0)     return {1'b1, 16'h0000};
      else if (sa < 0) return {1'b1, 16'h8000};
      else             return {1'b1, 16'h7FFF};
    end
    q = (sa * 256) / sb;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return {1'b0, 16'(q)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " wr_en"},    32'(wr_en),    32'd0);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " addr"},     32'(addr),     32'd0);
    check({tag, " D"},        32'(D),        32'd0);
    check({tag, " dz"},       32'(dz),       32'd0);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ready"}, 32'(in_ready), 32'd1);
  endtask

  // One complete operation with latency, payload and pulse-width checks
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] d,
                        input logic [15:0] exp_d, input logic exp_dz, input string name);
    int k;
    int lat;
    lat = exp_dz ? 0 : 24;
    wait_ready(name);
    dividend = a;
    divisor  = b;
    dst      = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    dst      = 4'($urandom);
    @(negedge clk);
    check({name, " busy"}, 32'(busy), 32'd1);
    k = 0;
    while (!wr_en && k < 40) begin
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(lat));
    if (wr_en) begin
      check({name, " addr"}, 32'(addr), 32'(d));
      check({name, " D"},    32'(D),    32'(exp_d));
      check({name, " dz"},   32'(dz),   32'(exp_dz));
      @(negedge clk);
      check({name, " wr_en drop"}, 32'(wr_en),    32'd0);
      check({name, " ready back"}, 32'(in_ready), 32'd1);
      check({name, " busy drop"},  32'(busy),     32'd0);
      check({name, " D hold"},     32'(D),        32'(exp_d));
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  d;
    logic [15:0] exp_d;
    logic        exp_dz;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic [15:0] ba [3];
    logic [15:0] bb [3];
    logic [3:0]  bd [3];
    int          k;
    int          sel;

    rst      = 1'b1;
    in_valid = 1'b0;
    dividend = '0;
    divisor  = '0;
    dst      = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    vecs[0] = '{16'd3,      16'd2,      4'd5,  16'h0180, 1'b0};
    vecs[1] = '{-16'sd3,    16'd2,      4'd6,  16'hFE80, 1'b0};
    vecs[2] = '{-16'sd3,    -16'sd2,    4'd7,  16'h0180, 1'b0};
    vecs[3] = '{16'd1,      -16'sd3,    4'd8,  16'hFFAB, 1'b0};
    vecs[4] = '{16'd32767,  16'd1,      4'd9,  16'h7FFF, 1'b0};
    vecs[5] = '{16'h8000,   16'd1,      4'd10, 16'h8000, 1'b0};
    vecs[6] = '{16'd1,      16'd300,    4'd11, 16'h0000, 1'b0};
    vecs[7] = '{16'd100,    16'd0,      4'd12, 16'h7FFF, 1'b1};
    vecs[8] = '{-16'sd5,    16'd0,      4'd13, 16'h8000, 1'b1};
    vecs[9] = '{16'd0,      16'd0,      4'd14, 16'h0000, 1'b1};

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].exp_d, vecs[i].exp_dz, $sformatf("vec%0d", i));

    @(negedge clk);
    check("readback rf5", 32'(rf[5]), 32'h0180);

    // Random operands, biased toward small and zero divisors
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rb = 16'd0;
      else if (sel < 4)  rb = 16'(int'($urandom_range(0, 6)) - 3);
      else if (sel < 6)  rb = 16'($urandom_range(1, 400));
      else               rb = 16'($urandom);
      if (sel < 2) ra = 16'(int'($urandom_range(0, 600)) - 300);
      r = ref_div(ra, rb);
      run_op(ra, rb, 4'($urandom), r[15:0], r[16], $sformatf("rnd%0d", i));
    end

    // Back-to-back with in_valid held and garbage inputs while busy
    pulse_cyc.delete();
    pulse_addr.delete();
    pulse_d.delete();
    ba[0] = 16'd1000;  bb[0] = 16'd3;      bd[0] = 4'd1;
    ba[1] = -16'sd700; bb[1] = 16'd9;      bd[1] = 4'd2;
    ba[2] = 16'd5;     bb[2] = -16'sd1;    bd[2] = 4'd3;
    wait_ready("b2b start");
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dividend = ba[i];
      divisor  = bb[i];
      dst      = bd[i];
      @(posedge clk);
      #1;
      dividend = 16'($urandom);
      divisor  = 16'($urandom) | 16'd1;
      dst      = 4'($urandom);
      if (i == 2) begin
        in_valid = 1'b0;
      end else begin
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 60) begin
          @(negedge clk);
          k++;
        end
      end
    end
    repeat (40) @(negedge clk);
    check("b2b pulses", 32'(pulse_cyc.size()), 32'd3);
    if (pulse_cyc.size() == 3) begin
      check("b2b gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd26);
      check("b2b gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd26);
      for (int i = 0; i < 3; i++) begin
        r = ref_div(ba[i], bb[i]);
        check($sformatf("b2b addr%0d", i), 32'(pulse_addr[i]), 32'(bd[i]));
        check($sformatf("b2b D%0d", i),    32'(pulse_d[i]),    32'(r[15:0]));
      end
    end

    // Reset in the middle of CALC aborts the op
    pulse_cyc.delete();
    pulse_addr.delete();
    pulse_d.delete();
    wait_ready("rst op");
    dividend = 16'd1000;
    divisor  = 16'd7;
    dst      = 4'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst no wr_en", 32'(pulse_cyc.size()), 32'd0);
    r = ref_div(16'd1000, 16'd7);
    run_op(16'd1000, 16'd7, 4'd9, r[15:0], r[16], "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
